// File: rtl/stack_rpn_engine.sv
// -----------------------------------------------------------------------------
// stack_rpn_engine
//
// Reverse-Polish evaluator that drives an external LIFO (push/pop/data_in/
// data_out/full/empty). It never stores operands itself: every operand lives
// in the attached stack, and operators pop their arguments and push the result.
//
// Optional feature: define RPN_MUL_EN to make opcode 5 a multiply (low DATA_W
// bits of a*b). Without it, opcode 5 is illegal and no multiplier is built.
//
// Ports
//   clk           clock, rising edge
//   rstN          synchronous reset, ACTIVE-HIGH despite the name
//   tok_valid     token offered by the front end
//   tok_ready     engine accepts a token this cycle (IDLE only)
//   tok_is_op     1 = tok_data is an opcode, 0 = operand
//   tok_data      operand value or opcode
//   stk_push      push strobe to the stack
//   stk_pop       pop strobe to the stack
//   stk_data_in   write data to the stack
//   stk_data_out  stack read data, valid the cycle after a pop
//   stk_full      stack full flag
//   stk_empty     stack empty flag
//   res_valid     one-cycle pulse when EMIT presents a result
//   res_data      last EMIT value, held until the next EMIT
//   err           sticky error flag
//   err_code      first error: 1 underflow, 2 overflow, 3 illegal opcode
//   err_clr       clears err/err_code; wins over a same-cycle new error
// -----------------------------------------------------------------------------
module stack_rpn_engine #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              tok_valid,
    output logic              tok_ready,
    input  logic              tok_is_op,
    input  logic [DATA_W-1:0] tok_data,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_data_in,
    input  logic [DATA_W-1:0] stk_data_out,
    input  logic              stk_full,
    input  logic              stk_empty,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              err,
    output logic [1:0]        err_code,
    input  logic              err_clr
);

    // DEPTH only documents the attached stack; full/empty come from the stack.
    if (DEPTH < 2) begin : g_depth_check
        $error("stack_rpn_engine: DEPTH must be at least 2");
    end

    localparam logic [DATA_W-1:0] OP_ADD  = DATA_W'(0);
    localparam logic [DATA_W-1:0] OP_SUB  = DATA_W'(1);
    localparam logic [DATA_W-1:0] OP_AND  = DATA_W'(2);
    localparam logic [DATA_W-1:0] OP_OR   = DATA_W'(3);
    localparam logic [DATA_W-1:0] OP_XOR  = DATA_W'(4);
`ifdef RPN_MUL_EN
    localparam logic [DATA_W-1:0] OP_MUL  = DATA_W'(5);
`endif
    localparam logic [DATA_W-1:0] OP_DUP  = DATA_W'(6);
    localparam logic [DATA_W-1:0] OP_EMIT = DATA_W'(7);
    localparam logic [DATA_W-1:0] OP_DROP = DATA_W'(8);

    localparam logic [1:0] ERR_UNDER   = 2'd1;
    localparam logic [1:0] ERR_OVER    = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH, S_PUSH2, S_POPB, S_WAITB, S_POPA, S_WAITA, S_ERR
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] op_q;       // opcode latched at accept
    logic [DATA_W-1:0] b_q;        // top-of-stack operand (b)
    logic [DATA_W-1:0] pushval;    // value presented on stk_data_in
    logic [1:0]        pend_code;  // error code carried into S_ERR

    function automatic logic is_binop(input logic [DATA_W-1:0] op);
        logic r;
        r = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
            (op == OP_OR)  || (op == OP_XOR);
`ifdef RPN_MUL_EN
        r = r || (op == OP_MUL);
`endif
        return r;
    endfunction

    // a = second-from-top, b = top; all results wrap modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] alu(input logic [DATA_W-1:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
`ifdef RPN_MUL_EN
            OP_MUL:  r = a * b;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    assign tok_ready   = (state == S_IDLE);
    // pushval is a register, so the stack write data is still a registered output.
    assign stk_data_in = pushval;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every branch below reads
        // the pre-edge value of each register regardless of statement order.
        if (rstN) begin
            // NOTE: every register is reset (there is no memory array here), so a
            // reset mid-token leaves no stale strobe or partial push behind.
            state     <= S_IDLE;
            op_q      <= '0;
            b_q       <= '0;
            pushval   <= '0;
            pend_code <= '0;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            err       <= 1'b0;
            err_code  <= '0;
        end else begin
            // Strobes are single-cycle unless a transition below re-asserts them.
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            res_valid <= 1'b0;

            if (err_clr) begin
                err      <= 1'b0;
                err_code <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (tok_valid) begin
                        op_q <= tok_data;
                        if (!tok_is_op) begin
                            if (stk_full) begin
                                pend_code <= ERR_OVER;
                                state     <= S_ERR;
                            end else begin
                                pushval  <= tok_data;
                                stk_push <= 1'b1;
                                state    <= S_PUSH;
                            end
                        end else if (is_binop(tok_data)) begin
                            if (stk_empty) begin
                                pend_code <= ERR_UNDER;
                                state     <= S_ERR;
                            end else begin
                                stk_pop <= 1'b1;
                                state   <= S_POPB;
                            end
                        end else if (tok_data == OP_DUP) begin
                            // DUP is net +1 entry, so it needs one free slot.
                            if (stk_empty) begin
                                pend_code <= ERR_UNDER;
                                state     <= S_ERR;
                            end else if (stk_full) begin
                                pend_code <= ERR_OVER;
                                state     <= S_ERR;
                            end else begin
                                stk_pop <= 1'b1;
                                state   <= S_POPA;
                            end
                        end else if (tok_data == OP_EMIT || tok_data == OP_DROP) begin
                            if (stk_empty) begin
                                pend_code <= ERR_UNDER;
                                state     <= S_ERR;
                            end else begin
                                stk_pop <= 1'b1;
                                state   <= S_POPA;
                            end
                        end else begin
                            pend_code <= ERR_ILLEGAL;
                            state     <= S_ERR;
                        end
                    end
                end

                S_POPB: state <= S_WAITB;

                S_WAITB: begin
                    b_q <= stk_data_out;
                    // Empty after popping b means there is no a: b is discarded.
                    if (stk_empty) begin
                        pend_code <= ERR_UNDER;
                        state     <= S_ERR;
                    end else begin
                        stk_pop <= 1'b1;
                        state   <= S_POPA;
                    end
                end

                S_POPA: state <= S_WAITA;

                S_WAITA: begin
                    // stk_data_out is operand a here.
                    if (is_binop(op_q)) begin
                        pushval  <= alu(op_q, stk_data_out, b_q);
                        stk_push <= 1'b1;
                        state    <= S_PUSH;
                    end else if (op_q == OP_DUP) begin
                        pushval  <= stk_data_out;
                        stk_push <= 1'b1;
                        state    <= S_PUSH2;
                    end else if (op_q == OP_EMIT) begin
                        res_data  <= stk_data_out;
                        res_valid <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_PUSH2: begin
                    stk_push <= 1'b1;
                    state    <= S_PUSH;
                end

                S_PUSH: state <= S_IDLE;

                S_ERR: begin
                    // First error wins; a clear in the same cycle wins over both.
                    if (!err_clr && !err) begin
                        err      <= 1'b1;
                        err_code <= pend_code;
                    end
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
